branch_controller: RTL and testbench
====================================

# branch_controller

Sequencer that owns the combinational branch-resolution datapath. It accepts one decoded conditional-branch op at a time, fetches rs1/rs2 through a shared, arbitrated register-file read port, and drives the branch datapath with the operands. It registers the datapath's next-PC and error outputs and returns a single response to the fetch stage: a redirect, or a trap for an illegal funct3 or a misaligned target.

## Interface
- No parameters; XLEN fixed at 32, register address 5 bits.
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- req_valid  in  1  branch op offered.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_pc  in  32  PC of branch.
- req_rs1, req_rs2  in  5  source register addresses.
- req_funct3  in  3  branch condition.
- req_b_immediate  in  32  sign-extended B-immediate.
- rf_read_request  out  1  request shared read port.
- rf_read_address  out  5  register being read.
- rf_read_grant  in  1  arbiter grant; data valid the cycle after.
- rf_read_data  in  32  read data.
- br_pc, br_lhs, br_rhs, br_b_immediate  out  32  datapath operands, held from registers.
- br_funct3  out  3  datapath condition.
- br_new_rd  in  32  datapath next PC.
- br_error  in  1  datapath illegal-funct3 flag.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_target  out  32  next PC (valid when resp_trap=0).
- resp_taken  out  1  resp_target != pc+4.
- resp_trap  out  1  response is a trap.
- resp_trap_cause  out  4  0 = misaligned target, 2 = illegal instruction.

## Operation
- States: IDLE, RS1_REQ, RS1_DATA, RS2_REQ, RS2_DATA, RESOLVE, RESPOND.
- IDLE: req_ready=1. On req_valid, latch pc, rs1, rs2, funct3 and immediate; clear lhs/rhs to 0.
  - funct3 in {2,3}: go to RESOLVE. Operand reads are skipped.
  - else rs1!=0: go to RS1_REQ.
  - else rs2!=0: go to RS2_REQ.
  - else: go to RESOLVE.
- RS1_REQ: rf_read_request=1, address=rs1. Wait for grant, then go to RS1_DATA.
- RS1_DATA: lhs <= rf_read_data. Next state is RS2_REQ if rs2!=0, else RESOLVE.
- RS2_REQ / RS2_DATA: same as RS1 for rs2/rhs. Then go to RESOLVE.
- x0 is never read from the port; its operand is 0.
- br_* outputs are driven continuously from the latched registers.
- RESOLVE: sample br_new_rd and br_error.
  - br_error=1: trap, cause 2, target ignored.
  - else br_new_rd[1:0]!=0: trap, cause 0.
  - else: redirect to br_new_rd.
  - resp_taken = (br_new_rd != pc+4), computed mod 2^32. An immediate of 4 therefore reports not-taken; the target is identical either way.
  - Go to RESPOND.
- RESPOND: resp_valid=1 and all resp_* fields held stable. On resp_ready, go to IDLE.
- br_error takes precedence over misalignment.

## Timing
- Reset values: req_ready=1 (IDLE). rf_read_request=0, rf_read_address=0, resp_valid=0, resp_taken=0, resp_trap=0, resp_trap_cause=0, resp_target=0, all br_* = 0.
- clear is asynchronous at any state. rf_read_request drops in the same instant, even mid-grant. Any in-flight response is discarded.
- rf_read_request stays asserted and the address stays stable until grant; grant with request low is ignored.
- rf_read_data is sampled exactly one cycle after grant, in the *_DATA state.
- Latency from acceptance edge (cycle 0) to resp_valid, with immediate grants:
  - both operands nonzero: cycle 6;
  - one nonzero: cycle 4;
  - neither, or illegal funct3: cycle 2.
  - Each stalled grant cycle adds 1.
- Back-to-back: resp_ready in RESPOND gives req_ready=1 the next cycle. There is no same-cycle accept while responding.
- Overflow: pc+imm and pc+4 wrap mod 2^32 with no trap. Only alignment is checked.

## Test plan
- BEQ taken, immediate grants: pc=0x100, rs1=x1=5, rs2=x2=5, imm=0x20, funct3=0 -> resp_valid at cycle 6, target=0x120, taken=1, trap=0.
- BLT not-taken, one grant stalled 3 cycles: lhs=0x7FFFFFFF, rhs=0x80000000, funct3=4 -> target=0x104, taken=0; resp_valid at cycle 9; rf_read_address held stable through the stall.
- Illegal funct3=3 with rs1=x5 -> no rf_read_request ever; resp_valid at cycle 2; trap=1, cause=2.
- Misaligned target: BNE, rs1=x0, rs2=x3=1, pc=0x200, imm=0x6 -> only one read issued (rs2); trap=1, cause=0.
- Response backpressure: resp_ready low 4 cycles -> all resp_* fields stable and req_ready=0 throughout; accept a new op the cycle after the handshake.
- clear asserted in RS2_REQ while rf_read_request=1 -> request drops asynchronously; all outputs at reset values; the next op completes normally.

Source files
------------

// File: rtl/branch_controller.sv
// Branch sequencer: fetches operands over a shared register-file read port, drives the
// branch-resolution datapath from latched registers and returns one redirect or trap.
module branch_controller (
   input  logic        clock_i,
   input  logic        clear_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_pc_i,
   input  logic [4:0]  req_rs1_i,
   input  logic [4:0]  req_rs2_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_b_immediate_i,
   output logic        rf_read_request_o,
   output logic [4:0]  rf_read_address_o,
   input  logic        rf_read_grant_i,
   input  logic [31:0] rf_read_data_i,
   output logic [31:0] br_pc_o,
   output logic [31:0] br_lhs_o,
   output logic [31:0] br_rhs_o,
   output logic [31:0] br_b_immediate_o,
   output logic [2:0]  br_funct3_o,
   input  logic [31:0] br_new_rd_i,
   input  logic        br_error_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_target_o,
   output logic        resp_taken_o,
   output logic        resp_trap_o,
   output logic [3:0]  resp_trap_cause_o
);

   typedef enum logic [2:0] {
      IDLE, RS1_REQ, RS1_DATA, RS2_REQ, RS2_DATA, RESOLVE, RESPOND
   } state_e;

   localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, imm_q, imm_d, lhs_q, lhs_d, rhs_q, rhs_d;
   logic [31:0] target_q, target_d;
   logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        taken_q, taken_d, trap_q, trap_d;
   logic [3:0]  cause_q, cause_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d           = state_q;
      pc_d              = pc_q;
      imm_d             = imm_q;
      lhs_d             = lhs_q;
      rhs_d             = rhs_q;
      rs1_d             = rs1_q;
      rs2_d             = rs2_q;
      funct3_d          = funct3_q;
      target_d          = target_q;
      taken_d           = taken_q;
      trap_d            = trap_q;
      cause_d           = cause_q;
      req_ready_o       = 1'b0;
      rf_read_request_o = 1'b0;
      rf_read_address_o = 5'd0;
      resp_valid_o      = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               pc_d     = req_pc_i;
               imm_d    = req_b_immediate_i;
               rs1_d    = req_rs1_i;
               rs2_d    = req_rs2_i;
               funct3_d = req_funct3_i;
               lhs_d    = 32'd0;
               rhs_d    = 32'd0;
               // funct3 2/3 are illegal: skip the reads and let the datapath flag it
               if (req_funct3_i[2:1] == 2'b01) state_d = RESOLVE;
               else if (req_rs1_i != 5'd0)      state_d = RS1_REQ;
               else if (req_rs2_i != 5'd0)      state_d = RS2_REQ;
               else                             state_d = RESOLVE;
            end
         end
         RS1_REQ: begin
            rf_read_request_o = 1'b1;
            rf_read_address_o = rs1_q;
            if (rf_read_grant_i) state_d = RS1_DATA;
         end
         RS1_DATA: begin
            lhs_d   = rf_read_data_i;
            state_d = (rs2_q != 5'd0) ? RS2_REQ : RESOLVE;
         end
         RS2_REQ: begin
            rf_read_request_o = 1'b1;
            rf_read_address_o = rs2_q;
            if (rf_read_grant_i) state_d = RS2_DATA;
         end
         RS2_DATA: begin
            rhs_d   = rf_read_data_i;
            state_d = RESOLVE;
         end
         RESOLVE: begin
            target_d = br_new_rd_i;
            taken_d  = (br_new_rd_i != pc_plus4);
            if (br_error_i) begin
               trap_d  = 1'b1;
               cause_d = CAUSE_ILLEGAL;
            end else if (br_new_rd_i[1:0] != 2'b00) begin
               trap_d  = 1'b1;
               cause_d = CAUSE_MISALIGNED;
            end else begin
               trap_d  = 1'b0;
               cause_d = CAUSE_MISALIGNED;
            end
            state_d = RESPOND;
         end
         RESPOND: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge clear_i) begin
      if (clear_i) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         imm_q    <= '0;
         lhs_q    <= '0;
         rhs_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         funct3_q <= '0;
         target_q <= '0;
         taken_q  <= 1'b0;
         trap_q   <= 1'b0;
         cause_q  <= '0;
      end else begin
         // NOTE: non-blocking so every register updates from the same pre-edge values.
         state_q  <= state_d;
         pc_q     <= pc_d;
         imm_q    <= imm_d;
         lhs_q    <= lhs_d;
         rhs_q    <= rhs_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         funct3_q <= funct3_d;
         target_q <= target_d;
         taken_q  <= taken_d;
         trap_q   <= trap_d;
         cause_q  <= cause_d;
      end
   end

   assign br_pc_o           = pc_q;
   assign br_lhs_o          = lhs_q;
   assign br_rhs_o          = rhs_q;
   assign br_b_immediate_o  = imm_q;
   assign br_funct3_o       = funct3_q;
   assign resp_target_o     = target_q;
   assign resp_taken_o      = taken_q;
   assign resp_trap_o       = trap_q;
   assign resp_trap_cause_o = cause_q;

endmodule

// File: tb/tb_branch_controller.sv
// Directed bench for branch_controller: models the register-file arbiter and the
// branch datapath, and checks latency, response fields, reads issued and reset.
module tb_branch_controller;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_pc = '0;
   logic [4:0]  req_rs1 = '0;
   logic [4:0]  req_rs2 = '0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_b_immediate = '0;
   logic        rf_read_request;
   logic [4:0]  rf_read_address;
   logic        rf_read_grant = 1'b0;
   logic [31:0] rf_read_data = '0;
   logic [31:0] br_pc, br_lhs, br_rhs, br_b_immediate;
   logic [2:0]  br_funct3;
   logic [31:0] br_new_rd;
   logic        br_error;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_target;
   logic        resp_taken;
   logic        resp_trap;
   logic [3:0]  resp_trap_cause;

   logic [31:0] regs [32];
   int passed = 0;
   int total = 0;
   int cyc, resp_cycle, reads, req_cycles, addr_viol, stall_left;
   logic [4:0] gaddr;
   logic       req_prev;
   logic [4:0] addr_prev;

   branch_controller dut (
      .clock_i(clock), .clear_i(clear),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_pc_i(req_pc), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
      .req_funct3_i(req_funct3), .req_b_immediate_i(req_b_immediate),
      .rf_read_request_o(rf_read_request), .rf_read_address_o(rf_read_address),
      .rf_read_grant_i(rf_read_grant), .rf_read_data_i(rf_read_data),
      .br_pc_o(br_pc), .br_lhs_o(br_lhs), .br_rhs_o(br_rhs),
      .br_b_immediate_o(br_b_immediate), .br_funct3_o(br_funct3),
      .br_new_rd_i(br_new_rd), .br_error_i(br_error),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_target_o(resp_target), .resp_taken_o(resp_taken),
      .resp_trap_o(resp_trap), .resp_trap_cause_o(resp_trap_cause)
   );

   always #5 clock = ~clock;

   // Reference branch datapath: {error, next_pc}
   function automatic logic [32:0] bru(logic [31:0] pc, logic [31:0] lhs, logic [31:0] rhs,
                                       logic [2:0] f3, logic [31:0] imm);
      logic t;
      logic e;
      t = 1'b0;
      e = 1'b0;
      case (f3)
         3'd0: t = (lhs == rhs);
         3'd1: t = (lhs != rhs);
         3'd4: t = ($signed(lhs) < $signed(rhs));
         3'd5: t = ($signed(lhs) >= $signed(rhs));
         3'd6: t = (lhs < rhs);
         3'd7: t = (lhs >= rhs);
         default: e = 1'b1;
      endcase
      return {e, t ? pc + imm : pc + 32'd4};
   endfunction

   assign {br_error, br_new_rd} = bru(br_pc, br_lhs, br_rhs, br_funct3, br_b_immediate);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: DUT edge, then arbiter and monitors update on the falling edge.
   task automatic tick();
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (rf_read_request && req_prev && !rf_read_grant && rf_read_address != addr_prev)
         addr_viol++;
      if (rf_read_request) req_cycles++;
      req_prev  = rf_read_request;
      addr_prev = rf_read_address;
      if (rf_read_grant) rf_read_data = regs[gaddr];
      if (rf_read_request) begin
         if (stall_left > 0) begin
            stall_left--;
            rf_read_grant = 1'b0;
         end else begin
            rf_read_grant = 1'b1;
            gaddr = rf_read_address;
            reads++;
         end
      end else begin
         rf_read_grant = 1'b0;
      end
      // cyc counts edges after acceptance; the spec's cycle number is the edge that samples resp_valid
      if (resp_valid && resp_cycle < 0) resp_cycle = cyc + 1;
   endtask

   task automatic issue_op(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [31:0] imm);
      reads = 0; req_cycles = 0; addr_viol = 0; resp_cycle = -1;
      check("accept_ready", 32'(req_ready), 32'd1);
      req_pc = pc; req_rs1 = rs1; req_rs2 = rs2; req_funct3 = f3; req_b_immediate = imm;
      req_valid = 1'b1;
      cyc = -1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      for (int i = 0; i < 40 && !resp_valid; i++) tick();
      check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
   endtask

   task automatic finish_resp(input string tag);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
      check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rf_req"}, 32'(rf_read_request), 32'd0);
      check({tag, "_rf_addr"}, 32'(rf_read_address), 32'd0);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_resp_fields"}, {resp_target[27:0], resp_taken, resp_trap, resp_trap_cause[1:0]}, 32'd0);
      check({tag, "_br_pc"}, br_pc, 32'd0);
      check({tag, "_br_ops"}, br_lhs | br_rhs | br_b_immediate | 32'(br_funct3), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      stall_left = 0; req_prev = 1'b0; addr_prev = '0; gaddr = '0;
      cyc = 0; resp_cycle = -1; reads = 0; req_cycles = 0; addr_viol = 0;

      // Reset state
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      clear = 1'b0;
      @(negedge clock);

      // BEQ taken, immediate grants
      regs[1] = 32'd5; regs[2] = 32'd5;
      issue_op(32'h100, 5'd1, 5'd2, 3'd0, 32'h20);
      wait_resp("beq");
      check("beq_latency", 32'(resp_cycle), 32'd6);
      check("beq_target", resp_target, 32'h120);
      check("beq_taken", 32'(resp_taken), 32'd1);
      check("beq_trap", 32'(resp_trap), 32'd0);
      check("beq_reads", 32'(reads), 32'd2);
      check("beq_lhs", br_lhs, 32'd5);
      finish_resp("beq");

      // BLT not taken (signed), first grant stalled 3 cycles
      regs[3] = 32'h7FFF_FFFF; regs[4] = 32'h8000_0000;
      stall_left = 3;
      issue_op(32'h100, 5'd3, 5'd4, 3'd4, 32'h40);
      wait_resp("blt");
      check("blt_latency", 32'(resp_cycle), 32'd9);
      check("blt_target", resp_target, 32'h104);
      check("blt_taken", 32'(resp_taken), 32'd0);
      check("blt_trap", 32'(resp_trap), 32'd0);
      check("blt_addr_stable", 32'(addr_viol), 32'd0);
      check("blt_rhs", br_rhs, 32'h8000_0000);
      finish_resp("blt");

      // Illegal funct3 = 3: no operand reads
      issue_op(32'h100, 5'd5, 5'd0, 3'd3, 32'h8);
      wait_resp("ill");
      check("ill_latency", 32'(resp_cycle), 32'd2);
      check("ill_no_request", 32'(req_cycles), 32'd0);
      check("ill_trap", 32'(resp_trap), 32'd1);
      check("ill_cause", 32'(resp_trap_cause), 32'd2);
      finish_resp("ill");

      // BNE x0 vs x3=1, target 0x206 misaligned
      regs[3] = 32'd1;
      issue_op(32'h200, 5'd0, 5'd3, 3'd1, 32'h6);
      wait_resp("mis");
      check("mis_latency", 32'(resp_cycle), 32'd4);
      check("mis_reads", 32'(reads), 32'd1);
      check("mis_read_addr", 32'(gaddr), 32'd3);
      check("mis_trap", 32'(resp_trap), 32'd1);
      check("mis_cause", 32'(resp_trap_cause), 32'd0);
      check("mis_taken", 32'(resp_taken), 32'd1);
      finish_resp("mis");

      // BGEU taken with pc+imm wrapping to 0, then 4 cycles of backpressure
      regs[6] = 32'd10; regs[7] = 32'd3;
      issue_op(32'hFFFF_FFF0, 5'd6, 5'd7, 3'd7, 32'h10);
      wait_resp("wrap");
      check("wrap_latency", 32'(resp_cycle), 32'd6);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_fields", {resp_target[28:0], resp_taken, resp_trap, resp_trap_cause[0]},
               32'b0000_0000_0000_0000_0000_0000_0000_0100);
      end
      finish_resp("wrap");

      // Accepted the cycle after the handshake: BGE x0,x0 taken, imm -8
      issue_op(32'h300, 5'd0, 5'd0, 3'd5, 32'hFFFF_FFF8);
      wait_resp("b2b");
      check("b2b_latency", 32'(resp_cycle), 32'd2);
      check("b2b_target", resp_target, 32'h2F8);
      check("b2b_taken", 32'(resp_taken), 32'd1);
      finish_resp("b2b");

      // clear while stalled in RS2_REQ
      stall_left = 5;
      issue_op(32'h400, 5'd0, 5'd2, 3'd0, 32'h10);
      tick();
      check("clr_pre_request", 32'(rf_read_request), 32'd1);
      #2 clear = 1'b1;
      #1;
      check_reset_outputs("clr");
      stall_left = 0; rf_read_grant = 1'b0; req_prev = 1'b0;
      @(negedge clock);
      clear = 1'b0;

      // Normal op after clear
      issue_op(32'h100, 5'd1, 5'd2, 3'd0, 32'h20);
      wait_resp("post");
      check("post_latency", 32'(resp_cycle), 32'd6);
      check("post_target", resp_target, 32'h120);
      check("post_trap", 32'(resp_trap), 32'd0);
      finish_resp("post");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
